// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction ROM.
// The fetch stage drives the word address; the ROM answers combinationally.
interface if_stage_if #(
    parameter int unsigned IM_AW = 10
);
    logic [IM_AW-1:0] imem_addr;
    logic [31:0]      imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the fetch PC, addresses the instruction ROM, and fills the IF/ID
// register. The next PC is chosen from the decode-stage redirect request.
// Delay-slot semantics mean the IF/ID register is never flushed.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [31:0] rs_data_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    npc_op_e     op;
    logic [31:0] pc_f;
    logic [31:0] pc_off;
    logic [31:0] pc_f4;
    logic [31:0] pc_d4;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        unused_bits;

    assign op = npc_op_e'(npc_op);

    // The ROM is based at PC_RESET; addresses outside it wrap silently.
    assign pc_off         = pc_f - PC_RESET;
    assign imem.imem_addr = pc_off[IM_AW+1:2];

    assign pc_f4  = pc_f + 32'd4;
    assign pc_d4  = pc_D + 32'd4;
    assign br_off = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};

    assign pc8_D = pc_D + 32'd8;

    assign unused_bits = ^{pc_off[31:IM_AW+2], pc_off[1:0], rs_data_D[1:0]};

    // Next-PC select: redirects are computed from the instruction sitting in D.
    always_comb begin
        npc = pc_f4;
        unique case (op)
            NPC_SEQ:    npc = pc_f4;
            NPC_BRANCH: npc = br_taken ? (pc_d4 + br_off) : pc_f4;
            NPC_JUMP:   npc = {pc_d4[31:28], instr_D[25:0], 2'b00};
            NPC_JR:     npc = {rs_data_D[31:2], 2'b00};
            default:    npc = pc_f4;
        endcase
    end

    // PC and IF/ID register update; stall freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f    <= PC_RESET;
            instr_D <= '0;
            pc_D    <= PC_RESET;
            valid_D <= 1'b0;
        end else if (!stall) begin
            pc_f    <= npc;
            instr_D <= imem.imem_rdata;
            pc_D    <= pc_f;
            valid_D <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural reference model pushes the
// expected IF/ID state to a scoreboard queue as each cycle's stimulus is
// driven; the entry is popped and compared just after the clock edge.
module tb_if_stage;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int unsigned IM_AW    = 10;

    typedef struct {
        logic [31:0] pcd;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic [31:0] valid;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_op = '0;
    logic        br_taken = 1'b0;
    logic [31:0] rs_data_D = '0;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;

    logic [31:0] rom [1024];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    if_stage_if #(.IM_AW(IM_AW)) imem_bus ();

    assign imem_bus.imem_rdata = rom[imem_bus.imem_addr];

    if_stage #(
        .PC_RESET(PC_RESET),
        .IM_AW   (IM_AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem_bus.master),
        .stall    (stall),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .rs_data_D(rs_data_D),
        .instr_D  (instr_D),
        .pc_D     (pc_D),
        .pc8_D    (pc8_D),
        .valid_D  (valid_D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_addr(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - PC_RESET;
        return {22'd0, off[11:2]};
    endfunction

    task automatic model_reset();
        m_pc    = PC_RESET;
        m_instr = '0;
        m_pcd   = PC_RESET;
        m_valid = 1'b0;
    endtask

    task automatic step(input logic [1:0] op, input logic taken,
                        input logic [31:0] rs, input logic stl);
        logic [31:0] npc;
        logic [31:0] pd4;
        logic [31:0] sext;
        exp_t e;
        npc_op    = op;
        br_taken  = taken;
        rs_data_D = rs;
        stall     = stl;
        if (!stl) begin
            pd4  = m_pcd + 32'd4;
            sext = {{16{m_instr[15]}}, m_instr[15:0]};
            case (op)
                2'd1:    npc = taken ? pd4 + (sext << 2) : m_pc + 32'd4;
                2'd2:    npc = {pd4[31:28], m_instr[25:0], 2'b00};
                2'd3:    npc = {rs[31:2], 2'b00};
                default: npc = m_pc + 32'd4;
            endcase
            m_instr = rom[m_addr(m_pc)];
            m_pcd   = m_pc;
            m_valid = 1'b1;
            m_pc    = npc;
        end
        e.pcd   = m_pcd;
        e.instr = m_instr;
        e.pc8   = m_pcd + 32'd8;
        e.valid = {31'd0, m_valid};
        e.addr  = m_addr(m_pc);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("pc_D", pc_D, e.pcd);
        chk("instr_D", instr_D, e.instr);
        chk("pc8_D", pc8_D, e.pc8);
        chk("valid_D", {31'd0, valid_D}, e.valid);
        chk("imem_addr", {22'd0, imem_bus.imem_addr}, e.addr);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_addr"}, {22'd0, imem_bus.imem_addr}, 32'd0);
        chk({tag, "_instr"}, instr_D, 32'd0);
        chk({tag, "_pcD"}, pc_D, 32'h0000_3000);
        chk({tag, "_pc8"}, pc8_D, 32'h0000_3008);
        chk({tag, "_valid"}, {31'd0, valid_D}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = i;
        rom[2] = 32'h1000_FFFE;   // beq, imm = -2
        rom[4] = 32'h0C00_0C10;   // jal 0x3040
        rom[8] = 32'h0C00_0C20;   // jal 0x3080
        model_reset();

        // Reset held across the first edge.
        #12;
        chk_reset_state("rst");
        reset = 1'b1;

        // Sequential fetch.
        step(2'd0, 1'b0, '0, 1'b0);
        step(2'd0, 1'b0, '0, 1'b0);
        step(2'd0, 1'b0, '0, 1'b0);
        chk("seq_pcD", pc_D, 32'h0000_3008);

        // Taken beq at 0x3008: target 0x3004, delay slot enters D.
        step(2'd1, 1'b1, '0, 1'b0);
        chk("beq_t_addr", {22'd0, imem_bus.imem_addr}, 32'd1);
        chk("beq_t_slot", instr_D, 32'd3);

        // Same beq, not taken.
        step(2'd0, 1'b0, '0, 1'b0);
        step(2'd0, 1'b0, '0, 1'b0);
        step(2'd1, 1'b0, '0, 1'b0);
        chk("beq_n_addr", {22'd0, imem_bus.imem_addr}, 32'd4);
        step(2'd0, 1'b0, '0, 1'b0);
        chk("beq_n_addr2", {22'd0, imem_bus.imem_addr}, 32'd5);

        // jal at 0x3010.
        chk("jal_pc8", pc8_D, 32'h0000_3018);
        step(2'd2, 1'b0, '0, 1'b0);
        chk("jal_addr", {22'd0, imem_bus.imem_addr}, 32'h10);

        // jr with misaligned target.
        step(2'd0, 1'b0, '0, 1'b0);
        step(2'd3, 1'b0, 32'h0000_3023, 1'b0);
        chk("jr_addr", {22'd0, imem_bus.imem_addr}, 32'd8);

        // Stall two cycles with jal in D, then release.
        step(2'd0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(2'd2, 1'b0, '0, 1'b1);
            chk("stall_instr", instr_D, 32'h0C00_0C20);
            chk("stall_pcD", pc_D, 32'h0000_3020);
            chk("stall_addr", {22'd0, imem_bus.imem_addr}, 32'd9);
        end
        step(2'd2, 1'b0, '0, 1'b0);
        chk("rel_addr", {22'd0, imem_bus.imem_addr}, 32'h20);
        step(2'd0, 1'b0, '0, 1'b0);
        chk("once_addr", {22'd0, imem_bus.imem_addr}, 32'h21);

        // Asynchronous reset mid-cycle.
        #3;
        reset = 1'b0;
        #1;
        chk_reset_state("async");
        model_reset();
        #2;
        reset = 1'b1;

        // Mixed random traffic including stalls and wrapping jr targets.
        for (int k = 0; k < 60; k++) begin
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, ($urandom_range(0, 3) == 0));
        end

        chk("sb_drain", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
